// File: rtl/som_train_scheduler_pkg.sv
// Shared constants and FSM state encoding for the SOM training scheduler.
package som_train_scheduler_pkg;

  localparam int unsigned NEURONS    = 64;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned EP_W_DEF   = 4;
  localparam int unsigned WIDX_W     = $clog2(NEURONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DIST,
    S_WAIT,
    S_UPD,
    S_DUMP,
    S_DONE
  } state_e;

endpackage

// File: rtl/som_train_scheduler_if.sv
// Control bus between the scheduler and the SOM datapath / RAMs.
interface som_train_scheduler_if
  import som_train_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned EP_W   = EP_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] RAM_IF_A;
  logic              RAM_IF_OE;
  logic              D_update;
  logic              W_update;
  logic [EP_W-1:0]   epoch;
  logic              map_pass;
  logic [ADDR_W-1:0] RAM_RESULT_A;
  logic              RAM_RESULT_WE;
  logic [ADDR_W-1:0] RAM_W_A;
  logic              RAM_W_WE;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    output RAM_IF_A, RAM_IF_OE, D_update, W_update, epoch, map_pass,
           RAM_RESULT_A, RAM_RESULT_WE, RAM_W_A, RAM_W_WE, busy, done
  );

  modport slave (
    output start,
    input  RAM_IF_A, RAM_IF_OE, D_update, W_update, epoch, map_pass,
           RAM_RESULT_A, RAM_RESULT_WE, RAM_W_A, RAM_W_WE, busy, done
  );

endinterface

// File: rtl/som_train_scheduler_step_counter.sv
// Wrapping up-counter 0..MAX with sync clear (wins over enable) and terminal flag.
module som_step_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    last_c_o = (cnt_q == W'(MAX));
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_c_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/som_train_scheduler.sv
// Sequencer for the SOM datapath: EPOCHS training passes, one mapping pass,
// then a 64-entry weight dump. Strobes are registered from the next state.
module som_train_scheduler
  import som_train_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 65536,
  parameter int unsigned EPOCHS     = 4,
  parameter int unsigned MIN_LAT    = 1,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned EP_W       = EP_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  som_train_scheduler_if.master        sched_if
);

  localparam int unsigned PIX_MAX  = NUM_PIXELS - 1;
  localparam int unsigned LAST_EP  = (EPOCHS > 0) ? EPOCHS - 1 : 0;
  localparam int unsigned WAIT_MAX = (MIN_LAT > 0) ? MIN_LAT - 1 : 0;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e state_q, state_d;
  logic   map_q, map_d;
  logic   oe_q, oe_d;
  logic   dupd_q, dupd_d;
  logic   wupd_q, wupd_d;
  logic   rwe_q, rwe_d;
  logic   wwe_q, wwe_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic              pix_clr, pix_en, pix_last;
  logic              ep_clr, ep_en, ep_last;
  logic              wt_clr, wt_en, wt_last;
  logic              wi_clr, wi_en, wi_last;
  logic [ADDR_W-1:0] pix_cnt;
  logic [EP_W-1:0]   ep_cnt;
  logic [WAIT_W-1:0] wt_cnt_unused;
  logic [WIDX_W-1:0] wi_cnt;

  som_step_counter #(.W(ADDR_W), .MAX(PIX_MAX)) u_pix (
    .clk(clk), .rst(rst), .clr_i(pix_clr), .en_i(pix_en),
    .cnt_o(pix_cnt), .last_c_o(pix_last)
  );

  // Epoch counts up to EPOCHS; reaching it marks the mapping pass.
  som_step_counter #(.W(EP_W), .MAX(EPOCHS)) u_epoch (
    .clk(clk), .rst(rst), .clr_i(ep_clr), .en_i(ep_en),
    .cnt_o(ep_cnt), .last_c_o(ep_last)
  );

  som_step_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait (
    .clk(clk), .rst(rst), .clr_i(wt_clr), .en_i(wt_en),
    .cnt_o(wt_cnt_unused), .last_c_o(wt_last)
  );

  som_step_counter #(.W(WIDX_W), .MAX(NEURONS - 1)) u_widx (
    .clk(clk), .rst(rst), .clr_i(wi_clr), .en_i(wi_en),
    .cnt_o(wi_cnt), .last_c_o(wi_last)
  );

  // Next-state, counter control and next-cycle strobe decode.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    pix_clr = 1'b0;
    pix_en  = 1'b0;
    ep_clr  = 1'b0;
    ep_en   = 1'b0;
    wt_clr  = 1'b0;
    wt_en   = 1'b0;
    wi_clr  = 1'b0;
    wi_en   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (sched_if.start) begin
          state_d = S_FETCH;
          pix_clr = 1'b1;
          ep_clr  = 1'b1;
          map_d   = (EPOCHS == 0);
        end
      end
      S_FETCH: state_d = S_DIST;
      S_DIST: begin
        wt_clr  = 1'b1;
        state_d = (MIN_LAT > 0) ? S_WAIT : S_UPD;
      end
      S_WAIT: begin
        wt_en = 1'b1;
        if (wt_last) state_d = S_UPD;
      end
      S_UPD: begin
        pix_en  = 1'b1;
        state_d = S_FETCH;
        if (pix_last) begin
          if (ep_last) begin
            map_d   = 1'b0;
            wi_clr  = 1'b1;
            state_d = S_DUMP;
          end else begin
            ep_en = 1'b1;
            map_d = (ep_cnt == EP_W'(LAST_EP));
          end
        end
      end
      S_DUMP: begin
        wi_en = 1'b1;
        if (wi_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    oe_d   = (state_d == S_FETCH) || (state_d == S_DIST);
    dupd_d = (state_d == S_DIST);
    wupd_d = (state_d == S_UPD) && !map_d;
    rwe_d  = (state_d == S_UPD) && map_d;
    wwe_d  = (state_d == S_DUMP);
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      map_q   <= 1'b0;
      oe_q    <= 1'b0;
      dupd_q  <= 1'b0;
      wupd_q  <= 1'b0;
      rwe_q   <= 1'b0;
      wwe_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      oe_q    <= oe_d;
      dupd_q  <= dupd_d;
      wupd_q  <= wupd_d;
      rwe_q   <= rwe_d;
      wwe_q   <= wwe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sched_if.RAM_IF_A      = pix_cnt;
  assign sched_if.RAM_IF_OE     = oe_q;
  assign sched_if.D_update      = dupd_q;
  assign sched_if.W_update      = wupd_q;
  assign sched_if.epoch         = ep_cnt;
  assign sched_if.map_pass      = map_q;
  assign sched_if.RAM_RESULT_A  = pix_cnt;
  assign sched_if.RAM_RESULT_WE = rwe_q;
  assign sched_if.RAM_W_A       = ADDR_W'(wi_cnt);
  assign sched_if.RAM_W_WE      = wwe_q;
  assign sched_if.busy          = busy_q;
  assign sched_if.done          = done_q;

endmodule

// File: tb/tb_som_train_scheduler.sv
// Scoreboard bench: three scheduler configurations driven with randomized start/reset timing.
module tb_som_train_scheduler;

  localparam int unsigned AW = 18;
  localparam int unsigned EW = 4;
  localparam int K_D = 0, K_W = 1, K_R = 2, K_WW = 3, K_DONE = 4;

  typedef struct {
    logic oe, dupd, wupd, rwe, wwe, busy, done, map;
    logic [AW-1:0] ifa, ra, wa;
    logic [EW-1:0] ep;
  } smp_t;

  typedef struct {
    int kind;
    int addr;
    int ep;
  } ev_t;

  int cfg_np[3] = '{4, 2, 3};
  int cfg_ep[3] = '{2, 0, 1};
  int cfg_ml[3] = '{1, 2, 0};

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] start_v;

  always #5 clk = ~clk;

  som_train_scheduler_if #(.ADDR_W(AW), .EP_W(EW)) bus0 ();
  som_train_scheduler_if #(.ADDR_W(AW), .EP_W(EW)) bus1 ();
  som_train_scheduler_if #(.ADDR_W(AW), .EP_W(EW)) bus2 ();

  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];

  som_train_scheduler #(.NUM_PIXELS(4), .EPOCHS(2), .MIN_LAT(1), .ADDR_W(AW), .EP_W(EW)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .sched_if(bus0)
  );
  som_train_scheduler #(.NUM_PIXELS(2), .EPOCHS(0), .MIN_LAT(2), .ADDR_W(AW), .EP_W(EW)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .sched_if(bus1)
  );
  som_train_scheduler #(.NUM_PIXELS(3), .EPOCHS(1), .MIN_LAT(0), .ADDR_W(AW), .EP_W(EW)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .sched_if(bus2)
  );

  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[3][$];
  smp_t cur[3];
  smp_t prev[3];
  int   since_d[3];
  int   since_busy[3];

  task automatic chk(string name, int id, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, id, act, want);
    end
  endtask

  function automatic int run_len(int id);
    return (cfg_ep[id] + 1) * cfg_np[id] * (3 + cfg_ml[id]) + 64;
  endfunction

  // Reference model: the full ordered event stream of one run.
  task automatic push_run(int id);
    for (int e = 0; e < cfg_ep[id]; e++)
      for (int p = 0; p < cfg_np[id]; p++) begin
        exp_q[id].push_back('{K_D, p, e});
        exp_q[id].push_back('{K_W, p, e});
      end
    for (int p = 0; p < cfg_np[id]; p++) begin
      exp_q[id].push_back('{K_D, p, cfg_ep[id]});
      exp_q[id].push_back('{K_R, p, cfg_ep[id]});
    end
    for (int w = 0; w < 64; w++) exp_q[id].push_back('{K_WW, w, cfg_ep[id]});
    exp_q[id].push_back('{K_DONE, 0, cfg_ep[id]});
  endtask

  task automatic pop_ev(int id, int kind, output ev_t e);
    e = '{-1, -1, -1};
    if (exp_q[id].size() == 0) begin
      total++;
      bad++;
      $display("FAIL event dut%0d: got unexpected kind %0d expected none", id, kind);
    end else begin
      e = exp_q[id].pop_front();
      chk("event_kind", id, kind, e.kind);
    end
  endtask

  task automatic mon_step(int id, smp_t s, logic r);
    ev_t e;
    if (r) begin
      prev[id]       = '{default: '0};
      since_d[id]    = 0;
      since_busy[id] = 0;
      return;
    end
    since_d[id]++;
    since_busy[id]++;
    chk("strobe_onehot", id, longint'(int'(s.dupd) + int'(s.wupd) + int'(s.rwe) + int'(s.wwe) <= 1), 1);
    if (s.busy && !prev[id].busy) since_busy[id] = 0;
    if (s.dupd) begin
      chk("dupd_after_oe", id, {prev[id].oe, prev[id].dupd, s.oe}, 3'b101);
      pop_ev(id, K_D, e);
      chk("if_addr_fetch", id, prev[id].ifa, e.addr);
      chk("if_addr_dist", id, s.ifa, e.addr);
      chk("d_epoch", id, s.ep, e.ep);
      chk("d_map_pass", id, s.map, e.ep == cfg_ep[id]);
      since_d[id] = 0;
    end
    if (s.wupd) begin
      pop_ev(id, K_W, e);
      chk("w_epoch", id, s.ep, e.ep);
      chk("w_map_pass", id, s.map, 0);
      chk("w_after_d", id, since_d[id], 1 + cfg_ml[id]);
    end
    if (s.rwe) begin
      pop_ev(id, K_R, e);
      chk("result_addr", id, s.ra, e.addr);
      chk("result_epoch", id, s.ep, e.ep);
      chk("result_after_d", id, since_d[id], 1 + cfg_ml[id]);
    end
    if (s.wwe) begin
      pop_ev(id, K_WW, e);
      chk("w_ram_addr", id, s.wa, e.addr);
      chk("dump_epoch", id, s.ep, e.ep);
    end
    if (s.done && !prev[id].done) begin
      pop_ev(id, K_DONE, e);
      chk("done_busy", id, s.busy, 0);
      chk("run_cycles", id, since_busy[id], run_len(id));
    end
    prev[id] = s;
  endtask

  always @(negedge clk) begin
    cur[0] = '{bus0.RAM_IF_OE, bus0.D_update, bus0.W_update, bus0.RAM_RESULT_WE, bus0.RAM_W_WE,
               bus0.busy, bus0.done, bus0.map_pass, bus0.RAM_IF_A, bus0.RAM_RESULT_A, bus0.RAM_W_A, bus0.epoch};
    cur[1] = '{bus1.RAM_IF_OE, bus1.D_update, bus1.W_update, bus1.RAM_RESULT_WE, bus1.RAM_W_WE,
               bus1.busy, bus1.done, bus1.map_pass, bus1.RAM_IF_A, bus1.RAM_RESULT_A, bus1.RAM_W_A, bus1.epoch};
    cur[2] = '{bus2.RAM_IF_OE, bus2.D_update, bus2.W_update, bus2.RAM_RESULT_WE, bus2.RAM_W_WE,
               bus2.busy, bus2.done, bus2.map_pass, bus2.RAM_IF_A, bus2.RAM_RESULT_A, bus2.RAM_W_A, bus2.epoch};
    for (int i = 0; i < 3; i++) mon_step(i, cur[i], rst_v[i]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_rst(int id);
    chk("rst_strobes", id, {cur[id].oe, cur[id].dupd, cur[id].wupd, cur[id].rwe,
                            cur[id].wwe, cur[id].busy, cur[id].done, cur[id].map}, 0);
    chk("rst_addrs", id, cur[id].ifa | cur[id].ra | cur[id].wa, 0);
    chk("rst_epoch", id, cur[id].ep, 0);
  endtask

  task automatic start_run(int id);
    repeat ($urandom_range(1, 4)) tick();
    start_v[id] = 1'b1;
    push_run(id);
    tick();
    start_v[id] = 1'b0;
    chk("done_clear", id, cur[id].done, 0);
    chk("busy_after_start", id, cur[id].busy, 1);
  endtask

  task automatic ignored_start(int id);
    repeat ($urandom_range(2, 8)) tick();
    start_v[id] = 1'b1;
    tick();
    start_v[id] = 1'b0;
  endtask

  task automatic wait_done(int id);
    int n = 0;
    while (!cur[id].done && n < run_len(id) + 50) begin
      tick();
      n++;
    end
    chk("done_reached", id, cur[id].done, 1);
    tick();
    tick();
    chk("done_held", id, cur[id].done, 1);
    chk("queue_empty", id, exp_q[id].size(), 0);
  endtask

  task automatic reset_mid_dump(int id, int at);
    int n = 0;
    while (!(cur[id].wwe && cur[id].wa == AW'(at)) && n < 1000) begin
      tick();
      n++;
    end
    chk("dump_reached", id, cur[id].wwe && cur[id].wa == AW'(at), 1);
    rst_v[id] = 1'b1;
    @(posedge clk);
    exp_q[id].delete();
    tick();
    chk_rst(id);
    rst_v[id] = 1'b0;
  endtask

  initial begin
    rst_v   = '1;
    start_v = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk_rst(i);
    rst_v = '0;
    tick();

    start_run(0);
    ignored_start(0);
    wait_done(0);
    start_run(0);
    wait_done(0);
    start_run(0);
    reset_mid_dump(0, 10);
    start_run(0);
    wait_done(0);

    start_run(1);
    wait_done(1);

    start_run(2);
    ignored_start(2);
    wait_done(2);
    start_run(2);
    reset_mid_dump(2, int'($urandom_range(0, 63)));
    start_run(2);
    wait_done(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
